// File: rtl/usb_rx_unstuff.sv
// usb_rx_unstuff: USB receive front stage. Decodes the NRZI line, removes the
// zero stuffed after six consecutive ones, flags stuffing violations and feeds
// the CRC16 checker with a data bit plus a bs_sending qualifier.
module usb_rx_unstuff #(
  parameter logic K_LEVEL = 1'b0,
  parameter int   CNT_W   = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             line_bit,
  output logic             out_bit,
  output logic             bs_sending,
  output logic             stuff_err,
  output logic             pkt_done,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ERROR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [2:0]       STUFF_RUN = 3'd6;

  state_t           state, state_next;
  logic             prev_line, prev_line_next;
  logic [2:0]       run, run_next;
  logic             out_bit_next;
  logic             bs_sending_next;
  logic             stuff_err_next;
  logic             pkt_done_next;
  logic [CNT_W-1:0] bit_count_next;

  // The first body bit is decoded against the K level of the final SYNC bit,
  // and the SYNC KK pair already counts as one 1 toward the stuffing run.
  logic             ref_line;
  logic [2:0]       run_cur;
  logic [CNT_W-1:0] count_base;
  logic             dec;

  // Next-state and next-output logic for the decode / unstuff machine.
  always_comb begin
    state_next      = state;
    prev_line_next  = prev_line;
    run_next        = run;
    out_bit_next    = out_bit;
    bs_sending_next = 1'b0;
    stuff_err_next  = 1'b0;
    pkt_done_next   = 1'b0;
    bit_count_next  = bit_count;

    ref_line   = (state == IDLE) ? K_LEVEL : prev_line;
    run_cur    = (state == IDLE) ? 3'd1 : run;
    count_base = (state == IDLE) ? '0 : bit_count;
    dec        = (line_bit == ref_line);

    if (in_valid) begin
      prev_line_next = line_bit;
    end

    case (state)
      IDLE, RUN: begin
        if (in_valid) begin
          state_next     = RUN;
          bit_count_next = count_base;
          if (run_cur == STUFF_RUN) begin
            if (!dec) begin
              run_next = 3'd0;
            end else begin
              stuff_err_next = 1'b1;
              state_next     = ERROR;
            end
          end else begin
            out_bit_next    = dec;
            bs_sending_next = 1'b1;
            bit_count_next  = (count_base == CNT_MAX) ? count_base : count_base + 1'b1;
            run_next        = dec ? run_cur + 3'd1 : 3'd0;
          end
        end else if (state == RUN) begin
          pkt_done_next = 1'b1;
          state_next    = IDLE;
        end
      end
      ERROR: begin
        if (!in_valid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared by synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      prev_line  <= K_LEVEL;
      run        <= 3'd0;
      out_bit    <= 1'b0;
      bs_sending <= 1'b0;
      stuff_err  <= 1'b0;
      pkt_done   <= 1'b0;
      bit_count  <= '0;
    end else begin
      state      <= state_next;
      prev_line  <= prev_line_next;
      run        <= run_next;
      out_bit    <= out_bit_next;
      bs_sending <= bs_sending_next;
      stuff_err  <= stuff_err_next;
      pkt_done   <= pkt_done_next;
      bit_count  <= bit_count_next;
    end
  end

endmodule

// File: tb/tb_usb_rx_unstuff.sv
// tb_usb_rx_unstuff: table vectors, directed corner sequences and random
// packets checked against a packet-level NRZI/unstuff reference model.
module tb_usb_rx_unstuff;

  localparam int CNT_W   = 12;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             line_bit;
  logic             out_bit;
  logic             bs_sending;
  logic             stuff_err;
  logic             pkt_done;
  logic [CNT_W-1:0] bit_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit bs;
    bit ob;
    bit se;
    bit pd;
    int cnt;
  } exp_t;

  typedef struct {
    bit   iv;
    bit   lb;
    exp_t e;
  } vec_t;

  vec_t vecs[$];
  bit   pkt_lines[$];
  bit   full_lines[$];
  bit   data_bits[$];
  exp_t exp_q[$];

  bit pb_line[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
  bit pb_dec[8]  = '{0, 0, 1, 1, 0, 0, 1, 1};

  // Free-running clock.
  always #5 clock = ~clock;

  usb_rx_unstuff #(.K_LEVEL(1'b0), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .line_bit  (line_bit),
    .out_bit   (out_bit),
    .bs_sending(bs_sending),
    .stuff_err (stuff_err),
    .pkt_done  (pkt_done),
    .bit_count (bit_count)
  );

  function automatic exp_t mk(bit bs, bit ob, bit se, bit pd, int cnt);
    exp_t e;
    e.bs  = bs;
    e.ob  = ob;
    e.se  = se;
    e.pd  = pd;
    e.cnt = cnt;
    return e;
  endfunction

  task automatic add_vec(input bit iv, input bit lb, input bit bs, input bit ob,
                         input bit se, input bit pd, input int cnt);
    vec_t v;
    v.iv = iv;
    v.lb = lb;
    v.e  = mk(bs, ob, se, pd, cnt);
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input bit rst, input bit iv, input bit lb);
    @(negedge clock);
    reset    = rst;
    in_valid = iv;
    line_bit = lb;
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input exp_t e);
    logic [CNT_W-1:0] want_cnt;
    want_cnt = e.cnt[CNT_W-1:0];
    checks++;
    if (bs_sending !== e.bs || stuff_err !== e.se || pkt_done !== e.pd ||
        bit_count !== want_cnt || (e.bs && out_bit !== e.ob)) begin
      errors++;
      $display("[TB] FAIL %s: got bs=%0b out=%0b err=%0b done=%0b cnt=%0d, expected bs=%0b out=%0b err=%0b done=%0b cnt=%0d",
               name, bs_sending, out_bit, stuff_err, pkt_done, bit_count,
               e.bs, e.ob, e.se, e.pd, e.cnt);
    end
  endtask

  // Reference: decode the whole packet, then walk the data stream counting
  // consecutive ones; one expected record per body bit plus one end record.
  task automatic build_model();
    bit prevl;
    bit d;
    int ones;
    int cnt;
    bit err;
    exp_q.delete();
    prevl = 1'b0;
    ones  = 1;
    cnt   = 0;
    err   = 1'b0;
    foreach (pkt_lines[i]) begin
      d     = (pkt_lines[i] == prevl);
      prevl = pkt_lines[i];
      if (err) begin
        exp_q.push_back(mk(0, 0, 0, 0, cnt));
      end else if (ones == 6) begin
        if (!d) begin
          ones = 0;
          exp_q.push_back(mk(0, 0, 0, 0, cnt));
        end else begin
          err = 1'b1;
          exp_q.push_back(mk(0, 0, 1, 0, cnt));
        end
      end else begin
        if (cnt < CNT_MAX) cnt++;
        exp_q.push_back(mk(1, d, 0, 0, cnt));
        ones = d ? ones + 1 : 0;
      end
    end
    exp_q.push_back(mk(0, 0, 0, !err, cnt));
  endtask

  task automatic run_packet(input string name, input int n_idle);
    exp_t last;
    build_model();
    foreach (pkt_lines[i]) begin
      apply_stimulus(1'b0, 1'b1, pkt_lines[i]);
      check_output($sformatf("%s_bit%0d", name, i), exp_q[i]);
    end
    last = exp_q[exp_q.size() - 1];
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output($sformatf("%s_end", name), last);
    for (int k = 1; k < n_idle; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output($sformatf("%s_idle%0d", name, k), mk(0, 0, 0, 0, last.cnt));
    end
  endtask

  // NRZI-encode data_bits (stuff bits included) into pkt_lines from K.
  task automatic encode_data();
    bit lvl;
    lvl = 1'b0;
    pkt_lines.delete();
    foreach (data_bits[i]) begin
      if (!data_bits[i]) lvl = ~lvl;
      pkt_lines.push_back(lvl);
    end
  endtask

  task automatic random_lines(input int len, input int repeat_pct);
    bit lvl;
    lvl = 1'b0;
    pkt_lines.delete();
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 99) >= repeat_pct) lvl = ~lvl;
      pkt_lines.push_back(lvl);
    end
  endtask

  // Main test sequence.
  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    line_bit = 1'b0;

    apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    check_output("reset_state", mk(0, 0, 0, 0, 0));
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("idle_after_reset", mk(0, 0, 0, 0, 0));

    // Plain byte, PID 0xCC.
    for (int i = 0; i < 8; i++) add_vec(1, pb_line[i], 1, pb_dec[i], 0, 0, i + 1);
    add_vec(0, 0, 0, 0, 0, 1, 8);
    add_vec(0, 0, 0, 0, 0, 0, 8);
    // Stuff removal.
    for (int i = 0; i < 5; i++) add_vec(1, 0, 1, 1, 0, 0, i + 1);
    add_vec(1, 1, 0, 0, 0, 0, 5);
    add_vec(1, 1, 1, 1, 0, 0, 6);
    add_vec(1, 0, 1, 0, 0, 0, 7);
    add_vec(0, 0, 0, 0, 0, 1, 7);
    add_vec(0, 0, 0, 0, 0, 0, 7);
    // Stuff violation, then more valid bits that stay suppressed.
    for (int i = 0; i < 5; i++) add_vec(1, 0, 1, 1, 0, 0, i + 1);
    add_vec(1, 0, 0, 0, 1, 0, 5);
    add_vec(1, 1, 0, 0, 0, 0, 5);
    add_vec(1, 0, 0, 0, 0, 0, 5);
    add_vec(0, 0, 0, 0, 0, 0, 5);
    add_vec(0, 0, 0, 0, 0, 0, 5);

    foreach (vecs[i]) begin
      apply_stimulus(1'b0, vecs[i].iv, vecs[i].lb);
      check_output($sformatf("vec%0d", i), vecs[i].e);
    end

    // Run continuity: five ones, stuff, one, zero, five ones (no second gap).
    data_bits = '{1, 1, 1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 1};
    encode_data();
    run_packet("continuity", 2);

    // Packet ending with a stuff bit still pending.
    data_bits = '{0, 1, 1, 1, 1, 1, 1};
    encode_data();
    run_packet("pending_stuff", 2);

    // Re-rise of in_valid right after it falls.
    data_bits = '{1, 0, 1, 1};
    encode_data();
    run_packet("short_gap_a", 1);
    data_bits = '{0, 0, 1};
    encode_data();
    run_packet("short_gap_b", 2);

    // Reset at body bit 20 of a 40-bit body.
    random_lines(40, 50);
    full_lines = pkt_lines;
    build_model();
    for (int i = 0; i < 19; i++) begin
      apply_stimulus(1'b0, 1'b1, full_lines[i]);
      check_output($sformatf("prerst_bit%0d", i), exp_q[i]);
    end
    apply_stimulus(1'b1, 1'b1, full_lines[19]);
    check_output("mid_reset", mk(0, 0, 0, 0, 0));
    pkt_lines = full_lines[20:39];
    run_packet("after_reset", 2);

    // Bit counter saturation: alternating line decodes to all zeros.
    pkt_lines.delete();
    for (int i = 0; i < CNT_MAX + 5; i++) pkt_lines.push_back(((i % 2) == 0) ? 1'b1 : 1'b0);
    run_packet("saturate", 2);

    // Random packets with random idle gaps.
    for (int p = 0; p < 40; p++) begin
      random_lines($urandom_range(1, 50), $urandom_range(40, 75));
      run_packet($sformatf("rand%0d", p), $urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
